// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the access-size, FSM-state and fault-cause encodings (the size and
// cause encodings are also used by main_decoder), plus small combinational
// helpers for alignment checking, byte-lane enables and store replication.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_BUS      = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_cause_t;

  // Size 2'b11 has no legal meaning, so it is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      SIZE_W:  return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 4'b0001 << lo;
      SIZE_H:  return 4'b0011 << {lo[1], 1'b0};
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the store data lets the memory pick any lane without a shifter.
  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load result alignment: selects the addressed byte/half lane of a bus read
// word and sign- or zero-extends it to 32 bits. Word loads pass through.
// Ports: rdata (bus read word), addr_lo (Addr[1:0]), size (MemSize),
//        sign (MemSign), result (extended 32-bit load value).
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_B:  result = {{24{sign & byte_sel[7]}}, byte_sel};
      SIZE_H:  result = {{16{sign & half_sel[15]}}, half_sel};
      SIZE_W:  result = rdata;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential data-memory access unit. Turns one decoded load/store into a
// single-word req/gnt/rvalid bus transaction with byte enables, stalls the
// core while the access is in flight and returns an aligned, extended load
// result with a one-cycle Done pulse (or a fault: misaligned/illegal, bus
// error, timeout).
// Ports: clk, rst (sync, active high); decoder controls MemRead, MemWrite,
//        MemSize, MemSign; Addr, WriteData from execute; Stall, Done,
//        ReadData, Fault, FaultCause to the core; bus_* to data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSign,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0]  addr_reg, wdata_reg, result_reg;
  logic [1:0]   size_reg;
  logic         we_reg, sign_reg, fault_reg;
  fault_cause_t cause_reg;
  logic [31:0]  load_value;
  logic         req_in, bad_req, timed_out;

  assign req_in    = MemRead | MemWrite;
  assign bad_req   = is_misaligned(MemSize, Addr[1:0]) | (MemRead & MemWrite);
  assign timed_out = (cnt == CNT_LAST);

  load_align u_align (
    .rdata   (bus_rdata),
    .addr_lo (addr_reg[1:0]),
    .size    (size_reg),
    .sign    (sign_reg),
    .result  (load_value)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. In REQ the timeout wins over a late grant so the
  // access can never outlive the budget; in RESP a response wins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_in) state_next = bad_req ? DONE : REQ;
      REQ:  if (timed_out) state_next = DONE;
            else if (bus_gnt) state_next = RESP;
      RESP: if (bus_rvalid || timed_out) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured request, timeout counter and completion status
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= '0;
      we_reg     <= 1'b0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      fault_reg  <= 1'b0;
      cause_reg  <= FC_NONE;
    end else begin
      case (state)
        IDLE: if (req_in) begin
          addr_reg   <= Addr;
          wdata_reg  <= WriteData;
          size_reg   <= MemSize;
          we_reg     <= MemWrite;
          sign_reg   <= MemSign;
          cnt        <= '0;
          result_reg <= '0;
          fault_reg  <= bad_req;
          cause_reg  <= bad_req ? FC_MISALIGN : FC_NONE;
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (timed_out) begin
            fault_reg <= 1'b1;
            cause_reg <= FC_TIMEOUT;
          end
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            if (bus_err) begin
              fault_reg <= 1'b1;
              cause_reg <= FC_BUS;
            end else if (!we_reg) begin
              result_reg <= load_value;
            end
          end else if (timed_out) begin
            fault_reg <= 1'b1;
            cause_reg <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus fields only while requesting, results only while Done
  always_comb begin
    Stall      = 1'b0;
    Done       = 1'b0;
    ReadData   = '0;
    Fault      = 1'b0;
    FaultCause = FC_NONE;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_be     = '0;
    bus_wdata  = '0;
    case (state)
      IDLE: Stall = req_in;
      REQ: begin
        Stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_reg;
        bus_addr  = {addr_reg[31:2], 2'b00};
        bus_be    = lane_enables(size_reg, addr_reg[1:0]);
        bus_wdata = replicate_store(size_reg, wdata_reg);
      end
      RESP: Stall = 1'b1;
      DONE: begin
        Done       = 1'b1;
        ReadData   = result_reg;
        Fault      = fault_reg;
        FaultCause = cause_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the test plan
// followed by randomized transactions, each checked against an arithmetic
// reference model of the access rules.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;
  localparam int MAX_CYC = TIMEOUT + 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemSign;
  logic [1:0]  MemSize;
  logic [31:0] Addr, WriteData;
  logic        Stall, Done, Fault;
  logic [31:0] ReadData;
  logic [1:0]  FaultCause;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSign(MemSign),
    .Addr(Addr), .WriteData(WriteData),
    .Stall(Stall), .Done(Done), .ReadData(ReadData), .Fault(Fault), .FaultCause(FaultCause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_bad(input bit rd, input bit wr, input int sz, input logic [31:0] a);
    int unsigned au;
    int unsigned nb;
    au = a;
    if (sz == 3 || (rd && wr)) return 1'b1;
    nb = 1 << sz;
    return (au % nb) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int sz, input bit sg, input logic [31:0] a,
                                             input logic [31:0] rdat);
    longint r, v, span;
    int unsigned au;
    int nb, lane;
    au   = a;
    r    = rdat;
    nb   = 1 << sz;
    lane = int'(au % 4);
    span = 64'd1 << (8 * nb);
    v    = (r >> (8 * lane)) & (span - 1);
    if (sg && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
    int unsigned au;
    int tmp;
    au = a;
    if (sz == 2) tmp = 15;
    else tmp = ((1 << (1 << sz)) - 1) << (au % 4);
    return tmp[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
    logic [31:0] o;
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % nb) +: 8];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, Stall, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_rdata"}, ReadData, 0);
    check({tag, "_fault"}, Fault, 0);
    check({tag, "_cause"}, FaultCause, 0);
    check({tag, "_req"}, bus_req, 0);
    check({tag, "_we"}, bus_we, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_be"}, bus_be, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
  endtask

  // Stray bus handshakes while idle must not produce a completion.
  task automatic stray_check(input string tag);
    @(negedge clk);
    bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_err = 1'b0;
    #1;
    check({tag, "_req"}, bus_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b0; bus_gnt = 1'b0;
      #1;
      check({tag, "_done"}, Done, 0);
    end
  endtask

  // gnt_dly < 0 withholds the grant forever.
  task automatic run_txn(input string name, input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] wd,
                         input int gnt_dly, input int rv_dly, input bit err,
                         input logic [31:0] rdat, output logic [31:0] got_rd);
    bit bad, tmo, granted, req_seen, done_seen;
    int stall_n, req_cnt, since, done_cyc, exp_done;
    logic [31:0] exp_rd;
    logic [1:0]  exp_cause;
    logic        exp_fault;
    logic        got_fault;
    logic [1:0]  got_cause;

    bad = model_bad(rd, wr, sz, a);
    tmo = !bad && gnt_dly < 0;
    granted = 0; req_seen = 0; done_seen = 0;
    stall_n = 0; req_cnt = 0; since = 0; done_cyc = -1;
    got_rd = '0; got_fault = 1'b0; got_cause = 2'b00;

    if (bad) begin
      exp_done = 1; exp_fault = 1; exp_cause = 2'd1; exp_rd = 0;
    end else if (tmo) begin
      exp_done = 1 + TIMEOUT; exp_fault = 1; exp_cause = 2'd3; exp_rd = 0;
    end else if (err) begin
      exp_done = 2 + gnt_dly + rv_dly; exp_fault = 1; exp_cause = 2'd2; exp_rd = 0;
    end else begin
      exp_done = 2 + gnt_dly + rv_dly; exp_fault = 0; exp_cause = 2'd0;
      exp_rd = wr ? 32'h0 : model_load(sz, sg, a, rdat);
    end

    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSign = sg; Addr = a; WriteData = wd;
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      #1;
      if (Done) begin
        done_seen = 1; done_cyc = cyc;
        got_rd = ReadData; got_fault = Fault; got_cause = FaultCause;
        check({name, "_stall_at_done"}, Stall, 0);
        break;
      end
      if (Stall) stall_n++;
      if (bus_req) begin
        if (!req_seen && !bad) begin
          check({name, "_we"}, bus_we, wr);
          check({name, "_addr"}, bus_addr, a & 32'hFFFF_FFFC);
          check({name, "_be"}, bus_be, model_be(sz, a));
          if (wr) check({name, "_wdata"}, bus_wdata, model_wdata(sz, wd));
        end
        req_seen = 1;
        if (req_cnt == gnt_dly) begin bus_gnt = 1'b1; granted = 1; end
        req_cnt++;
      end else if (granted) begin
        since++;
        if (since == rv_dly) begin bus_rvalid = 1'b1; bus_err = err; bus_rdata = rdat; end
      end
      @(negedge clk);
    end
    MemRead = 1'b0; MemWrite = 1'b0;

    check({name, "_done_seen"}, done_seen, 1);
    check({name, "_done_cycle"}, done_cyc, exp_done);
    check({name, "_stall_cycles"}, stall_n, exp_done);
    check({name, "_bus_used"}, req_seen, !bad);
    check({name, "_fault"}, got_fault, exp_fault);
    check({name, "_cause"}, got_cause, exp_cause);
    check({name, "_rdata"}, got_rd, exp_rd);
    $display("[TB] %s: rd=%0d wr=%0d size=%0d addr=0x%08h gnt_dly=%0d err=%0d done_cycle=%0d fault=%0d cause=%0d rdata=0x%08h",
             name, rd, wr, sz, a, gnt_dly, err, done_cyc, got_fault, got_cause, got_rd);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd_val, ra, rw, rr;
  logic [1:0]  rs;
  bit          r_rd, r_wr, r_sg, r_err;
  int          k, v, gd, rvd;

  initial begin
    rst = 1'b1; MemRead = 0; MemWrite = 0; MemSize = 0; MemSign = 0; Addr = 0; WriteData = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    run_txn("lb_signed", 1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 0, 1, 0, 32'h80FF_1234, rd_val);
    check("lb_signed_const", rd_val, 32'hFFFF_FF80);
    run_txn("lhu", 1, 0, 2'b01, 0, 32'h0000_1002, 32'h0, 0, 1, 0, 32'h8001_0000, rd_val);
    check("lhu_const", rd_val, 32'h0000_8001);
    run_txn("sb", 0, 1, 2'b10 - 2'b10, 0, 32'h0000_2001, 32'h1234_56AB, 0, 1, 0, 32'h0, rd_val);
    run_txn("lw_misaligned", 1, 0, 2'b10, 0, 32'h0000_3002, 32'h0, 0, 1, 0, 32'h0, rd_val);
    run_txn("size_illegal", 1, 0, 2'b11, 0, 32'h0000_3002, 32'h0, 0, 1, 0, 32'h0, rd_val);
    run_txn("sw_timeout", 0, 1, 2'b10, 0, 32'h0000_4000, 32'hDEAD_BEEF, -1, 1, 0, 32'h0, rd_val);
    stray_check("late_rvalid");
    run_txn("lw_bus_err", 1, 0, 2'b10, 0, 32'h0000_5000, 32'h0, 4, 1, 1, 32'hCAFE_F00D, rd_val);

    // Reset while waiting for the response.
    @(negedge clk);
    MemRead = 1; MemSize = 2'b10; Addr = 32'h0000_6000;
    @(negedge clk);
    #1;
    check("rst_mid_in_req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("rst_mid_in_resp", {31'h0, bus_req} | {30'h0, Stall, 1'b0}, 32'h2);
    rst = 1'b1; MemRead = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("rst_mid");
    stray_check("rst_stray");
    $display("[TB] rst_mid: reset in RESP, unit idle afterwards");

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 9);
      r_rd = (k < 5) || (k == 9);
      r_wr = (k >= 5);
      v = $urandom_range(0, 9);
      rs = (v < 3) ? 2'd0 : (v < 6) ? 2'd1 : (v < 9) ? 2'd2 : 2'd3;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      rw = $urandom; rr = $urandom;
      r_sg = 1'($urandom_range(0, 1));
      r_err = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 4);
      rvd = $urandom_range(1, 3);
      run_txn($sformatf("rand%0d", t), r_rd, r_wr, rs, r_sg, ra, rw, gd, rvd, r_err, rr, rd_val);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
